// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared types, defaults and helpers for the instruction fetch stage
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          FQ_ENTRY_W       = 64;

    // IDLE: free to request; WAIT: one granted read in flight;
    // DROP: the in-flight read belongs to a squashed path and is discarded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_q.sv
// rtl/if_fetch_q.sv - two-entry fetch queue holding {pc, instruction} pairs
//
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   flush           empties the queue; wins over push/pop in the same cycle
//   push, push_data write an entry (dropped when full unless popping too)
//   pop             retire the head entry (ignored when empty)
//   head_data       current head, valid when count != 0
//   count           occupancy 0..2
module if_fetch_q
    import if_fetch_pkg::*;
#(
    parameter int W = FQ_ENTRY_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && ((count != 2'd2) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with one outstanding read and a 2-entry queue
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   stall                       decode holds the delivered instruction
//   br, branch_addr             taken branch for the delivered instruction and its target
//   imem_req, imem_addr         read request and word-aligned address
//   imem_gnt                    request accepted when imem_req & imem_gnt
//   imem_rvalid, imem_rdata     in-order read response
//   pc_out, inst_out, inst_valid  instruction delivered to decode
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid
);

    fetch_state_t state;
    logic [31:0]  fpc;
    logic [31:0]  req_pc;
    logic [31:0]  last_pc;
    logic         run;

    fetch_entry_t q_head;
    fetch_entry_t q_push_data;
    logic [1:0]   q_count;
    logic         q_valid;
    logic         q_push;
    logic         q_pop;
    logic         redirect;
    logic         fire;

    assign q_valid  = (q_count != 2'd0);
    assign q_pop    = q_valid && !stall;
    assign redirect = br && !stall && q_valid;

    // run holds requests off until the first edge that samples reset released.
    assign imem_req  = run && (state == ST_IDLE) && (q_count != 2'd2) && !redirect;
    assign imem_addr = fpc;
    assign fire      = imem_req && imem_gnt;

    // A response that lands in the redirect cycle belongs to the squashed path.
    assign q_push      = (state == ST_WAIT) && imem_rvalid && !redirect;
    assign q_push_data = '{pc: req_pc, inst: imem_rdata};

    assign inst_valid = q_valid;
    assign inst_out   = q_valid ? q_head.inst : NOP_INST;
    assign pc_out     = q_valid ? q_head.pc : last_pc;

    if_fetch_q #(
        .W(FQ_ENTRY_W)
    ) u_q (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .push     (q_push),
        .push_data(q_push_data),
        .pop      (q_pop),
        .head_data(q_head),
        .count    (q_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            fpc     <= word_align(RESET_PC);
            req_pc  <= word_align(RESET_PC);
            last_pc <= RESET_PC;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (q_pop) begin
                last_pc <= q_head.pc;
            end
            if (fire) begin
                req_pc <= fpc;
            end
            if (redirect) begin
                fpc <= word_align(branch_addr);
                // Any read still owed by memory must be swallowed before
                // fetching on the new path.
                case (state)
                    ST_WAIT, ST_DROP: state <= imem_rvalid ? ST_IDLE : ST_DROP;
                    default:          state <= fire ? ST_DROP : ST_IDLE;
                endcase
            end else begin
                if (fire) begin
                    fpc <= fpc + 32'd4;
                end
                case (state)
                    ST_IDLE: if (fire) state <= ST_WAIT;
                    ST_WAIT: if (imem_rvalid) state <= ST_IDLE;
                    ST_DROP: if (imem_rvalid) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard testbench for if_fetch
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;

    logic        zero_in;
    logic [31:0] zero_addr;
    logic        gnt2;
    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2 = 32'd0;
    logic [31:0] pc2;
    logic [31:0] inst2;
    logic        valid2;

    int          errors = 0;
    int          checks = 0;
    int          lat = 1;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk(clk), .reset(reset), .stall(stall), .br(br), .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .inst_out(inst_out), .inst_valid(inst_valid)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .stall(zero_in), .br(zero_in), .branch_addr(zero_addr),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .pc_out(pc2), .inst_out(inst2), .inst_valid(valid2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Main memory: fixed latency 'lat' cycles from grant to rvalid; cleared by reset.
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'd0;
    always @(posedge clk) begin
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (imem_rvalid) pend = 1'b0;
            if (imem_req && imem_gnt) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = lat - 1;
            end else if (pend && cnt > 0) begin
                cnt--;
            end
        end
        #1;
        imem_rvalid = pend && (cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(paddr) : 32'hDEAD_BEEF;
    end

    // Memory for the wrap instance: single-cycle latency.
    logic        pend2 = 1'b0;
    logic [31:0] paddr2 = 32'd0;
    always @(posedge clk) begin
        if (!reset) begin
            pend2 = 1'b0;
        end else begin
            if (rvalid2) pend2 = 1'b0;
            if (req2 && gnt2) begin
                pend2  = 1'b1;
                paddr2 = addr2;
            end
        end
        #1;
        rvalid2 = pend2;
        rdata2  = mem_word(paddr2);
    end

    // Monitors: compare every delivered instruction against the scoreboard.
    always @(negedge clk) begin
        if (reset && inst_valid && !stall && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("deliver_pc", pc_out, mon_e);
            chk("deliver_inst", inst_out, mem_word(mon_e));
        end
        if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    end

    logic [31:0] exp2 [3];
    int          idx2 = 0;
    always @(negedge clk) begin
        if (!reset) begin
            idx2 = 0;
        end else if (valid2) begin
            if (idx2 < 3) chk("wrap_reset_pc", pc2, exp2[idx2]);
            idx2++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        reset       = 1'b0;
        stall       = 1'b0;
        br          = 1'b0;
        branch_addr = 32'd0;
        lat         = l;
        tick;
        tick;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst_out, NOP_INST_DEFAULT);
        chk("rst_pc", pc_out, RESET_PC_DEFAULT);
    endtask

    task automatic release_rst;
        reset = 1'b1;
        tick;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        int n = 0;
        while (!(inst_valid && pc_out == pc) && n < 200) begin
            tick;
            n++;
        end
        chk("reach_pc", (inst_valid && pc_out == pc) ? pc : pc_out, pc);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp2[0]   = 32'hFFFF_FFFC;
        exp2[1]   = 32'h0000_0000;
        exp2[2]   = 32'h0000_0004;
        zero_in   = 1'b0;
        zero_addr = 32'd0;
        gnt2      = 1'b1;
        imem_gnt  = 1'b1;

        // Sequential fetch, 1-cycle memory, first valid in cycle 3.
        do_reset(1);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        release_rst;
        tick;
        tick;
        chk("cycle3_valid", inst_valid, 1);
        chk("cycle3_pc", pc_out, 32'h0);
        wait_drain("seq_drain");

        // Stall at 0x8 for 3 cycles: queue fills, requests stop.
        do_reset(1);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        release_rst;
        wait_pc(32'h8);
        stall = 1'b1;
        tick;
        chk("stall_hold_pc", pc_out, 32'h8);
        tick;
        chk("stall_full_req", imem_req, 0);
        chk("stall_hold_pc2", pc_out, 32'h8);
        chk("stall_valid", inst_valid, 1);
        tick;
        stall = 1'b0;
        wait_drain("stall_drain");

        // Redirect with a read in flight (latency 2): stale 0x8 dropped.
        do_reset(2);
        exp_q = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h108};
        release_rst;
        wait_pc(32'h4);
        stall = 1'b1;
        tick;
        chk("inflight_no_req", imem_req, 0);
        stall       = 1'b0;
        br          = 1'b1;
        branch_addr = 32'h0000_0103;
        tick;
        br = 1'b0;
        chk("drop_no_req", imem_req, 0);
        chk("drop_empty", inst_valid, 0);
        tick;
        chk("target_req", imem_req, 1);
        chk("target_addr", imem_addr, 32'h100);
        wait_drain("redirect_drain");

        // Branch while stalled is ignored.
        do_reset(1);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        release_rst;
        wait_pc(32'h4);
        stall       = 1'b1;
        br          = 1'b1;
        branch_addr = 32'h200;
        tick;
        tick;
        chk("stallbr_pc", pc_out, 32'h4);
        stall = 1'b0;
        br    = 1'b0;
        wait_drain("stallbr_drain");

        // Fetch address wraps past 0xFFFF_FFFC.
        do_reset(1);
        exp_q = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        release_rst;
        wait_pc(32'h0);
        br          = 1'b1;
        branch_addr = 32'hFFFF_FFF8;
        tick;
        br = 1'b0;
        wait_drain("wrap_drain");

        // Reset while a 3-cycle read is in flight.
        do_reset(3);
        release_rst;
        tick;
        chk("midwait_no_req", imem_req, 0);
        do_reset(3);
        exp_q = '{32'h0, 32'h4};
        release_rst;
        wait_drain("midwait_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
